// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus grant arbiter: source count, index width,
// the arbiter state encoding and the default maximum hold time.
// The optional hold-time limit is enabled by defining BUS_ARB_TIMEOUT_EN.
package bus_arb_pkg;

  localparam int NUM_SRC_C    = 32;
  localparam int SEL_W        = 5;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // One-hot vector with only bit 'sel' set.
  function automatic logic [NUM_SRC_C-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_SRC_C-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Combinational round-robin selector. The request vector is rotated so that
// bit ptr lands at position 0, the lowest set bit is found with a fixed
// priority search, and ptr is added back (5-bit wrap) to recover the source.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_SRC_C-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     sel,
  output logic                 any
);

  logic [2*NUM_SRC_C-1:0] req_dbl;
  logic [NUM_SRC_C-1:0]   rot;
  logic [SEL_W-1:0]       first_idx;

  // Rotate right by ptr so the search starts at source ptr.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot     = req_dbl[NUM_SRC_C-1:0];
  end

  // Fixed-priority find-first: lowest set bit of the rotated vector wins.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_SRC_C - 1; i >= 0; i--) begin
      if (rot[i]) first_idx = SEL_W'(i);
    end
  end

  assign sel = first_idx + ptr;
  assign any = |req;

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus grant arbiter with a registered one-hot grant and one dead
// cycle between owners. Handshake: a source owns the bus from the cycle its
// grant bit is visible until it drops req or pulses done; the grant then goes
// to zero for at least one cycle before any new owner is chosen.
// Optional hold-time limit compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_grant_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_SRC  = NUM_SRC_C,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [NUM_SRC_C-1:0] req,
  input  logic                 done,
  output logic [NUM_SRC_C-1:0] grant,
  output logic                 grant_valid,
  output logic [SEL_W-1:0]     owner,
  output logic                 timeout,
  output arb_state_e           dbg_state
);

  arb_state_e           state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [NUM_SRC_C-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]     owner_q, owner_d;
  logic                 grant_valid_q, grant_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 release_c;
  logic [SEL_W-1:0]     pick_sel;
  logic                 pick_any;

  // Parameters that only matter for bookkeeping in some builds.
  logic unused_params;
  assign unused_params = ^{NUM_SRC[7:0], MAX_HOLD[7:0]};

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = MAX_HOLD[7:0];
  logic [7:0] hold_q, hold_d;
`endif

  rr_pick u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  // Next-state logic: arbitrate in IDLE, hold or release in GRANT.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    release_c     = done || !req[owner_q];
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d        = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d       = GRANT;
          grant_d       = onehot(pick_sel);
          owner_d       = pick_sel;
          grant_valid_d = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d        = '0;
`endif
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          ptr_d         = owner_q + SEL_W'(1);
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_q + 8'd1 == HOLD_LIM) begin
          // Forced revoke: same as a release, flagged for one cycle.
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          ptr_d         = owner_q + SEL_W'(1);
          timeout_d     = 1'b1;
        end else begin
          hold_d        = hold_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      owner_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q        <= hold_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign owner       = owner_q;
  assign timeout     = timeout_q;
  assign dbg_state   = state_q;

endmodule
